// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_sbox / aes_key_expand                                       |
// | Purpose  : Iterative AES-128 key schedule emitting rk0..rk10 over a        |
// |            valid/ready handshake, with a NUM-byte parallel S-box.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module aes_sbox #(
   parameter int NUM = 4
) (
   input  logic [8*NUM-1:0] i_data,
   output logic [8*NUM-1:0] o_data
);

   localparam logic [7:0] c_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   for (genvar g = 0; g < NUM; g++) begin : g_byte
      assign o_data[8*g +: 8] = c_SBOX[i_data[8*g +: 8]];
   end

endmodule

module aes_key_expand #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         done
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Indexed by the index of the key being replaced, so entry 0 is Rcon[1].
   localparam logic [7:0] c_RCON [16] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   state_t         r_state;
   logic [127:0]   r_rk;
   logic [3:0]     r_idx;
   logic           r_valid;
   logic           r_done;

   logic [31:0]    w_w0, w_w1, w_w2, w_w3;
   logic [31:0]    w_rot, w_sub, w_t;
   logic [31:0]    w_n0, w_n1, w_n2, w_n3;
   logic           w_accept;
   logic           w_last;

   assign w_w0 = r_rk[127:96];
   assign w_w1 = r_rk[95:64];
   assign w_w2 = r_rk[63:32];
   assign w_w3 = r_rk[31:0];

   assign w_rot = {w_w3[23:0], w_w3[31:24]};

   aes_sbox #(
      .NUM (4)
   ) u_sbox (
      .i_data (w_rot),
      .o_data (w_sub)
   );

   assign w_t  = w_sub ^ {c_RCON[r_idx], 24'h000000};
   assign w_n0 = w_w0 ^ w_t;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;

   assign w_accept = r_valid && rk_ready;
   assign w_last   = (r_idx == 4'(NR));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rk    <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rk    <= key_in;
                  r_idx   <= '0;
                  r_valid <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_rk  <= {w_n0, w_n1, w_n2, w_n3};
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = (r_state == S_RUN);
   assign rk_valid = r_valid;
   assign rk_out   = r_rk;
   assign rk_idx   = r_idx;
   assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_key_expand                                               |
// | Purpose  : Scoreboard bench for aes_key_expand against a GF(2^8) model.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module tb_aes_key_expand;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   localparam logic [127:0] c_K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] c_K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] c_K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] c_K0_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] c_K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key_in = '0;
   logic         rk_ready = 1'b1;
   logic         busy, rk_valid, done;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;

   int           errors = 0;
   int           checks = 0;
   exp_t         q[$];
   bit           m_busy = 1'b0;
   bit           pending_done = 1'b0;
   bit           ready_rand = 1'b0;
   int           pops = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];

   always #5 clk = ~clk;

   aes_key_expand #(
      .NR (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_idx   (rk_idx),
      .done     (done)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: S-box from the GF(2^8) inverse plus affine map.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp ^= {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
   task automatic issue(input logic [127:0] key, input bit use_kat,
                        input logic [127:0] kat1, input logic [127:0] kat10);
      expand(key);
      if (use_kat) begin
         exp_rk[0]  = key;
         exp_rk[1]  = kat1;
         exp_rk[10] = kat10;
      end
      for (int r = 0; r < 11; r++) q.push_back('{idx: 4'(r), key: exp_rk[r]});
      pops   = 0;
      key_in = key;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      m_busy = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((q.size() != 0 || pending_done || m_busy) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0 || pending_done || m_busy) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, %0d keys outstanding", name, q.size());
         q.delete();
         pending_done = 1'b0;
         m_busy = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_busy"},  128'(busy),     128'(0));
      check({name, "_valid"}, 128'(rk_valid), 128'(0));
      check({name, "_rk"},    rk_out,         128'(0));
      check({name, "_idx"},   128'(rk_idx),   128'(0));
      check({name, "_done"},  128'(done),     128'(0));
   endtask

   always @(posedge clk) begin
      #1;
      rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: handshakes are judged at negedge, before the edge that commits them.
   bit           stall_v = 1'b0;
   logic [127:0] stall_key;
   logic [3:0]   stall_idx;
   exp_t         e;

   always @(negedge clk) begin
      if (rst) begin
         stall_v = 1'b0;
      end else begin
         check("done", 128'(done), 128'(pending_done));
         pending_done = 1'b0;
         check("busy", 128'(busy), 128'(m_busy));
         if (stall_v) begin
            check("stall_valid", 128'(rk_valid), 128'(1));
            check("stall_rk", rk_out, stall_key);
            check("stall_idx", 128'(rk_idx), 128'(stall_idx));
         end
         stall_v = 1'b0;
         if (rk_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rk: idx %0d rk %h with nothing expected", rk_idx, rk_out);
            end else if (rk_ready) begin
               e = q.pop_front();
               pops++;
               check("rk_idx", 128'(rk_idx), 128'(e.idx));
               check("rk_out", rk_out, e.key);
               if (e.idx == 4'd10) begin
                  pending_done = 1'b1;
                  m_busy = 1'b0;
               end
            end else begin
               stall_v   = 1'b1;
               stall_key = rk_out;
               stall_idx = rk_idx;
            end
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      issue(c_K1, 1'b1, c_K1_R1, c_K1_R10);
      wait_idle("fips_key");

      issue(128'h0, 1'b1, c_K0_R1, c_K0_R10);
      wait_idle("zero_key");

      ready_rand = 1'b1;
      issue(c_K1, 1'b1, c_K1_R1, c_K1_R10);
      wait_idle("backpressure");

      issue(c_K1, 1'b1, c_K1_R1, c_K1_R10);
      repeat (3) begin
         @(posedge clk); #1;
      end
      key_in = 128'hffeeddccbbaa99887766554433221100;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      wait_idle("start_in_run");
      ready_rand = 1'b0;

      issue(c_K1, 1'b1, c_K1_R1, c_K1_R10);
      n = 0;
      while (pops < 5 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_idx", 128'(rk_idx), 128'(5));
      rst = 1'b1;
      q.delete();
      pending_done = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      rst    = 1'b0;
      m_busy = 1'b0;
      @(posedge clk); #1;
      issue(c_K1, 1'b1, c_K1_R1, c_K1_R10);
      wait_idle("after_abort");

      issue(c_K1, 1'b1, c_K1_R1, c_K1_R10);
      n = 0;
      while (!(pending_done && q.size() == 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      issue(128'h000102030405060708090a0b0c0d0e0f, 1'b0, '0, '0);
      check("b2b_valid", 128'(rk_valid), 128'(1));
      check("b2b_busy", 128'(busy), 128'(1));
      wait_idle("back_to_back");

      rst    = 1'b1;
      start  = 1'b1;
      key_in = c_K1;
      @(posedge clk); #1;
      rst    = 1'b0;
      start  = 1'b0;
      check_reset_outputs("start_rst");
      repeat (3) begin
         @(posedge clk); #1;
      end

      for (int k = 0; k < 4; k++) begin
         ready_rand = k[0];
         issue({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, '0);
         wait_idle("random_key");
      end
      ready_rand = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
